// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ctrl_pkg
//  Description : Shared types and constants for the fetch/execute controller:
//                FSM state enum, instruction opcodes and ALU opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // Controller states, encoded in the order the datapath sequence visits them.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_FWAIT  = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_EWAIT  = 3'd5,
    ST_WB     = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  // Instruction opcodes (instr[15:12]).
  localparam logic [3:0] c_OP_LOAD     = 4'h1;
  localparam logic [3:0] c_OP_STORE    = 4'h2;
  localparam logic [3:0] c_OP_ADD      = 4'h3;
  localparam logic [3:0] c_OP_SUB      = 4'h4;
  localparam logic [3:0] c_OP_HALT     = 4'h7;
  localparam logic [3:0] c_OP_SKIPCOND = 4'h8;
  localparam logic [3:0] c_OP_JUMP     = 4'h9;
  localparam logic [3:0] c_OP_CLEAR    = 4'hA;

  // ALU opcodes driven onto alu_op.
  localparam logic [3:0] c_ALU_ADD = 4'b0000;
  localparam logic [3:0] c_ALU_SUB = 4'b0001;

  // Opcodes that need an operand memory access after EXEC.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == c_OP_LOAD) || (op == c_OP_STORE) ||
           (op == c_OP_ADD)  || (op == c_OP_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wait_timer
//  Description : 3-bit down-counter that times main-memory read latency.
//                load reloads MEM_LAT-1, count decrements and stops at zero
//                (no wrap), done flags the final wait cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
  parameter int MEM_LAT = 1  // legal 1..7
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic done
);

  localparam logic [2:0] c_RELOAD = 3'(MEM_LAT - 1);

  logic [2:0] r_cnt;

  // Reload on wait-state entry, then count down and hold at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 3'd0;
    end else if (load) begin
      r_cnt <= c_RELOAD;
    end else if (count && (r_cnt != 3'd0)) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  assign done = (r_cnt == 3'd0);

endmodule
`default_nettype wire

// File: rtl/fetch_exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_exec_ctrl
//  Description : Fetch/decode/execute control FSM for a simple accumulator
//                machine. Produces datapath strobes for MAR/MBR/IR/PC/ACC and
//                memory write, with a configurable memory read latency.
//  Options     : CTRL_SKIPCOND_EN - when defined, opcode 0x8 is SKIPCOND
//                (conditional PC increment on accumulator flags); otherwise
//                0x8 is a NOP and acc_neg/acc_zero are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_exec_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1  // main-memory read latency, legal 1..7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] instr,
  input  logic        acc_neg,
  input  logic        acc_zero,
  output logic        mar_load,
  output logic        mar_sel,
  output logic        mbr_load,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        acc_load,
  output logic        acc_clr,
  output logic        mem_we,
  output logic [3:0]  alu_op,
  output logic        busy,
  output logic        halted,
  output logic [2:0]  state
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_op;
  logic       w_tmr_load;
  logic       w_tmr_count;
  logic       w_tmr_done;
  logic       w_skip;

  mem_wait_timer #(
    .MEM_LAT (MEM_LAT)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .load  (w_tmr_load),
    .count (w_tmr_count),
    .done  (w_tmr_done)
  );

`ifdef CTRL_SKIPCOND_EN
  // Skip condition selected by instr[11:10]; 11 never skips.
  always_comb begin
    w_skip = 1'b0;
    case (instr[11:10])
      2'b00:   w_skip = acc_neg;
      2'b01:   w_skip = acc_zero;
      2'b10:   w_skip = !acc_neg && !acc_zero;
      default: w_skip = 1'b0;
    endcase
  end

  logic w_unused_operand;
  assign w_unused_operand = &{1'b0, instr[9:0]};
`else
  assign w_skip = 1'b0;

  // Operand address and accumulator flags are only consumed by the datapath.
  logic w_unused_inputs;
  assign w_unused_inputs = &{1'b0, instr[11:0], acc_neg, acc_zero};
`endif

  // State register; reset returns to IDLE from anywhere, mid-instruction too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Remember the executing opcode so EWAIT/WB do not depend on IR stability.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op <= 4'h0;
    end else if (r_state == ST_EXEC) begin
      r_op <= instr[15:12];
    end
  end

  // Next-state and Moore/Mealy strobe decode; every output defaults low.
  always_comb begin
    w_next      = r_state;
    mar_load    = 1'b0;
    mar_sel     = 1'b0;
    mbr_load    = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    acc_load    = 1'b0;
    acc_clr     = 1'b0;
    mem_we      = 1'b0;
    alu_op      = c_ALU_ADD;
    busy        = 1'b1;
    halted      = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_count = 1'b0;

    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (run) w_next = ST_FETCH;
      end

      ST_FETCH: begin
        mar_load   = 1'b1;
        w_tmr_load = 1'b1;
        w_next     = ST_FWAIT;
      end

      ST_FWAIT: begin
        if (w_tmr_done) begin
          mbr_load = 1'b1;
          w_next   = ST_DECODE;
        end else begin
          w_tmr_count = 1'b1;
        end
      end

      ST_DECODE: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
        w_next  = ST_EXEC;
      end

      ST_EXEC: begin
        w_next = ST_FETCH;
        if (is_mem_op(instr[15:12])) begin
          mar_sel    = 1'b1;
          mar_load   = 1'b1;
          w_tmr_load = 1'b1;
          w_next     = ST_EWAIT;
        end else begin
          case (instr[15:12])
            c_OP_HALT:     w_next  = ST_HALT;
            c_OP_JUMP:     pc_load = 1'b1;
            c_OP_CLEAR:    acc_clr = 1'b1;
            c_OP_SKIPCOND: pc_inc  = w_skip;
            default:       ;
          endcase
        end
      end

      ST_EWAIT: begin
        if (r_op == c_OP_STORE) begin
          mem_we = 1'b1;
          w_next = ST_FETCH;
        end else if (w_tmr_done) begin
          mbr_load = 1'b1;
          w_next   = ST_WB;
        end else begin
          w_tmr_count = 1'b1;
        end
      end

      ST_WB: begin
        acc_load = 1'b1;
        // LOAD clears the accumulator input so the add yields ACC = 0 + MBR.
        if (r_op == c_OP_LOAD) acc_clr = 1'b1;
        if (r_op == c_OP_SUB)  alu_op  = c_ALU_SUB;
        w_next = ST_FETCH;
      end

      ST_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end

      default: begin
        busy   = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fetch_exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_exec_ctrl
//  Description : Scoreboard bench for fetch_exec_ctrl. The stimulus side
//                expands each instruction into the cycle-by-cycle output
//                sequence the controller must produce and queues it; a
//                monitor on the falling edge pops and compares.
//                Honours CTRL_SKIPCOND_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_exec_ctrl;

  localparam int MEM_LAT = 3;

  // State numbers follow the order IDLE..HALT.
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_FWAIT = 3'd2,
                         S_DECODE = 3'd3, S_EXEC = 3'd4, S_EWAIT = 3'd5,
                         S_WB = 3'd6, S_HALT = 3'd7;

  // Strobe bits: {mar_load, mar_sel, mbr_load, ir_load, pc_inc, pc_load,
  //               acc_load, acc_clr, mem_we}
  localparam logic [8:0] B_MARLD = 9'h100, B_MARSEL = 9'h080, B_MBR = 9'h040,
                         B_IR = 9'h020, B_PCINC = 9'h010, B_PCLD = 9'h008,
                         B_ACCLD = 9'h004, B_ACCCLR = 9'h002, B_WE = 9'h001;

  typedef struct packed {
    logic [2:0] st;
    logic [8:0] strb;
    logic [3:0] alu;
    logic       busy;
    logic       halted;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] instr;
  logic        acc_neg, acc_zero;
  logic        mar_load, mar_sel, mbr_load, ir_load, pc_inc, pc_load;
  logic        acc_load, acc_clr, mem_we;
  logic [3:0]  alu_op;
  logic        busy, halted;
  logic [2:0]  state;

  fetch_exec_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr),
    .acc_neg(acc_neg), .acc_zero(acc_zero),
    .mar_load(mar_load), .mar_sel(mar_sel), .mbr_load(mbr_load),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .acc_load(acc_load), .acc_clr(acc_clr), .mem_we(mem_we),
    .alu_op(alu_op), .busy(busy), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  vec_t  q_exp[$];
  string q_tag[$];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic vec_t v(input logic [2:0] st, input logic [8:0] s,
                             input logic [3:0] alu);
    vec_t r;
    r.st     = st;
    r.strb   = s;
    r.alu    = alu;
    r.busy   = (st != S_IDLE) && (st != S_HALT);
    r.halted = (st == S_HALT);
    return r;
  endfunction

  // Monitor: compare whatever the stimulus expected for this cycle.
  vec_t  m_exp, m_act;
  string m_tag;
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      m_exp = q_exp.pop_front();
      m_tag = q_tag.pop_front();
      m_act = {state, mar_load, mar_sel, mbr_load, ir_load, pc_inc, pc_load,
               acc_load, acc_clr, mem_we, alu_op, busy, halted};
      n_vec++;
      if (m_act !== m_exp) begin
        n_err++;
        $display("FAIL %s @%0t: got st=%0d strb=%b alu=%b busy=%b halted=%b, expected st=%0d strb=%b alu=%b busy=%b halted=%b",
                 m_tag, $time, m_act.st, m_act.strb, m_act.alu, m_act.busy, m_act.halted,
                 m_exp.st, m_exp.strb, m_exp.alu, m_exp.busy, m_exp.halted);
      end
    end
  end

  // Queue the expectation for the current cycle and advance one clock.
  task automatic step(input vec_t e, input string tag);
    q_exp.push_back(e);
    q_tag.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Busy-phase step: run toggles randomly and must be ignored.
  task automatic bstep(input vec_t e, input string tag);
    run = 1'($urandom_range(0, 1));
    step(e, tag);
  endtask

  task automatic hard_reset();
    reset = 1'b1;
    run   = 1'b0;
    step('0, "reset_hold");
    step('0, "reset_hold");
    reset = 1'b0;
    step(v(S_IDLE, 9'h0, 4'h0), "idle_after_reset");
  endtask

  task automatic start_run();
    run = 1'b1;
    step(v(S_IDLE, 9'h0, 4'h0), "idle_run");
  endtask

  // Expand one instruction into its expected cycle sequence.
  // ended=1 when the controller left the instruction stream (HALT or reset).
  task automatic do_instr(input logic [15:0] ins, input logic neg, input logic zero,
                          input bit rst_ewait, output bit ended);
    logic [3:0] op;
    logic       skip;
    op    = ins[15:12];
    ended = 1'b0;
    bstep(v(S_FETCH, B_MARLD, 4'h0), "fetch");
    for (int i = 0; i < MEM_LAT; i++)
      bstep(v(S_FWAIT, (i == MEM_LAT - 1) ? B_MBR : 9'h0, 4'h0), "fwait");
    bstep(v(S_DECODE, B_IR | B_PCINC, 4'h0), "decode");
    // IR now holds the new instruction.
    instr    = ins;
    acc_neg  = neg;
    acc_zero = zero;
    if (op == 4'h1 || op == 4'h2 || op == 4'h3 || op == 4'h4) begin
      bstep(v(S_EXEC, B_MARSEL | B_MARLD, 4'h0), "exec_mem");
      if (rst_ewait) begin
        reset = 1'b1;
        run   = 1'b0;
        step('0, "reset_in_ewait");
        reset = 1'b0;
        for (int i = 0; i < 3; i++)
          step(v(S_IDLE, 9'h0, 4'h0), "idle_after_abort");
        ended = 1'b1;
      end else if (op == 4'h2) begin
        bstep(v(S_EWAIT, B_WE, 4'h0), "store_we");
      end else begin
        for (int i = 0; i < MEM_LAT; i++)
          bstep(v(S_EWAIT, (i == MEM_LAT - 1) ? B_MBR : 9'h0, 4'h0), "ewait");
        bstep(v(S_WB, B_ACCLD | ((op == 4'h1) ? B_ACCCLR : 9'h0),
                (op == 4'h4) ? 4'b0001 : 4'b0000), "wb");
      end
    end else begin
      skip = 1'b0;
`ifdef CTRL_SKIPCOND_EN
      if (op == 4'h8)
        skip = (ins[11:10] == 2'b00 && neg) || (ins[11:10] == 2'b01 && zero) ||
               (ins[11:10] == 2'b10 && !neg && !zero);
`endif
      case (op)
        4'h7: begin
          bstep(v(S_EXEC, 9'h0, 4'h0), "exec_halt");
          ended = 1'b1;
        end
        4'h9:    bstep(v(S_EXEC, B_PCLD, 4'h0), "exec_jump");
        4'hA:    bstep(v(S_EXEC, B_ACCCLR, 4'h0), "exec_clear");
        4'h8:    bstep(v(S_EXEC, skip ? B_PCINC : 9'h0, 4'h0), "exec_skipcond");
        default: bstep(v(S_EXEC, 9'h0, 4'h0), "exec_nop");
      endcase
    end
  endtask

  task automatic hold_halt();
    run = 1'b1;
    for (int i = 0; i < 20; i++) step(v(S_HALT, 9'h0, 4'h0), "halt_hold");
  endtask

  // Stimulus
  initial begin
    bit         ended;
    logic [3:0] op;
    logic [15:0] ins;
    reset = 1'b1; run = 1'b0; instr = 16'h0; acc_neg = 1'b0; acc_zero = 1'b0;
    @(posedge clk);
    #1;
    hard_reset();

    // Directed program
    start_run();
    do_instr(16'h1005, 1'b0, 1'b0, 1'b0, ended);
    do_instr(16'h2010, 1'b0, 1'b0, 1'b0, ended);
    do_instr(16'h9040, 1'b0, 1'b0, 1'b0, ended);
    do_instr(16'h3002, 1'b0, 1'b0, 1'b0, ended);
    do_instr(16'h4123, 1'b1, 1'b0, 1'b0, ended);
    do_instr(16'hA000, 1'b0, 1'b0, 1'b0, ended);
    do_instr(16'h8400, 1'b0, 1'b1, 1'b0, ended);
    do_instr(16'h8400, 1'b0, 1'b0, 1'b0, ended);
    do_instr(16'h8000, 1'b1, 1'b0, 1'b0, ended);
    do_instr(16'h8800, 1'b0, 1'b0, 1'b0, ended);
    do_instr(16'h8C00, 1'b1, 1'b1, 1'b0, ended);
    do_instr(16'h5FFF, 1'b0, 1'b0, 1'b0, ended);
    // Reset while an ADD waits on memory
    do_instr(16'h3002, 1'b0, 1'b0, 1'b1, ended);
    start_run();
    do_instr(16'h7000, 1'b0, 1'b0, 1'b0, ended);
    hold_halt();
    hard_reset();

    // Random programs
    for (int r = 0; r < 4; r++) begin
      start_run();
      ended = 1'b0;
      for (int k = 0; k < 40 && !ended; k++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'h7) op = 4'h0;
        ins = {op, 12'($urandom_range(0, 4095))};
        do_instr(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 (r == 2) && ($urandom_range(0, 9) == 0), ended);
      end
      if (!ended) begin
        do_instr(16'h7ABC, 1'b0, 1'b0, 1'b0, ended);
        hold_halt();
        hard_reset();
      end
    end

    if (q_exp.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/fetch_exec_ctrl.md
FETCH_EXEC_CTRL -- requirements
Module: fetch_exec_ctrl

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning main-memory read latency in cycles (legal 1..7).
REQ-002 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port run  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port instr  input  16  current IR contents; [15:12] opcode, [11:0] operand address.
REQ-006 SHALL have ports acc_neg, acc_zero  input  1 each  accumulator sign and zero flags.
REQ-007 SHALL have ports mar_load, mar_sel, mbr_load, ir_load, pc_inc, pc_load, acc_load, acc_clr, mem_we  output  1 each  datapath strobes (mar_sel 0=PC, 1=instr[11:0]).
REQ-008 SHALL have port alu_op  output  4  ALU opcode (0000 add, 0001 sub).
REQ-009 SHALL have ports busy, halted  output  1 each  and state  output  3  current FSM state encoding.

Function
REQ-010 SHALL implement states IDLE, FETCH, FWAIT, DECODE, EXEC, EWAIT, WB, HALT.
REQ-011 IDLE: run=1 -> FETCH next cycle; run=0 -> stay; busy=0.
REQ-012 FETCH: mar_sel=0, mar_load=1 for one cycle -> FWAIT.
REQ-013 FWAIT: wait counter runs MEM_LAT cycles; mbr_load=1 in final wait cycle only -> DECODE.
REQ-014 DECODE: ir_load=1, pc_inc=1 for one cycle -> EXEC.
REQ-015 EXEC decodes instr[15:12]: LOAD 0x1, STORE 0x2, ADD 0x3, SUB 0x4 assert mar_sel=1, mar_load=1 -> EWAIT; HALT 0x7 -> HALT; JUMP 0x9 pc_load=1 -> FETCH; CLEAR 0xA acc_clr=1 -> FETCH; all other opcodes are NOPs -> FETCH.
REQ-016 EWAIT: STORE asserts mem_we=1 for exactly one cycle then -> FETCH; LOAD/ADD/SUB count MEM_LAT cycles, mbr_load=1 in final cycle -> WB.
REQ-017 WB: acc_load=1 one cycle; alu_op=0000 for ADD, 0001 for SUB; LOAD asserts acc_clr=1 with acc_load=1 and alu_op=0000 (ACC=0+MBR) -> FETCH.
REQ-018 alu_op SHALL be 0000 in every state other than WB.
REQ-019 HALT: halted=1, busy=0, all strobes 0; run ignored; exit only via reset.
REQ-020 busy SHALL be 1 in every state except IDLE and HALT.
REQ-021 Wait counter SHALL be 3 bits, reload to MEM_LAT-1 on entry to FWAIT/EWAIT, no wrap; MEM_LAT=1 gives single-cycle wait.
REQ-022 At most one of pc_inc/pc_load SHALL be asserted per cycle; mem_we and mbr_load SHALL never be asserted together.
REQ-023 run toggling while busy SHALL have no effect.

Reset
REQ-024 reset SHALL force IDLE, wait counter 0, all outputs 0 (including halted, busy, alu_op) asynchronously, including mid-instruction.
REQ-025 First rising edge after reset deassertion SHALL evaluate IDLE transition rules.

Configuration
REQ-026 With CTRL_SKIPCOND_EN defined, opcode 0x8 SKIPCOND in EXEC SHALL assert pc_inc=1 when instr[11:10]=00 and acc_neg, =01 and acc_zero, =10 and !acc_neg and !acc_zero; instr[11:10]=11 never skips; -> FETCH.
REQ-027 Without CTRL_SKIPCOND_EN, opcode 0x8 SHALL be a NOP and acc_neg/acc_zero SHALL be unused.

Structure
REQ-028 Shared package ctrl_pkg SHALL hold the state enum, opcode constants and alu_op constants.
REQ-029 Wait counter SHALL be sub-module mem_wait_timer (load, count, done).

Verification
REQ-030 reset then run=1, instr=0x1005, MEM_LAT=1 -> FETCH,FWAIT,DECODE,EXEC,EWAIT,WB; acc_load+acc_clr in cycle 6; returns to FETCH.
REQ-031 instr=0x2010 -> exactly one mem_we pulse in EWAIT, no acc_load, no mbr_load.
REQ-032 instr=0x9040 -> pc_load=1 in EXEC, no pc_inc that cycle; instr=0x7000 -> halted=1 held for 20 cycles with run=1.
REQ-033 MEM_LAT=3, instr=0x3002 -> FWAIT and EWAIT each last 3 cycles; mbr_load only in last; alu_op=0000 with acc_load in WB.
REQ-034 CTRL_SKIPCOND_EN, instr=0x8400, acc_zero=1 -> pc_inc in EXEC; acc_zero=0 -> no pc_inc.
REQ-035 reset asserted during EWAIT of ADD -> all outputs 0 same cycle, state IDLE, no acc_load after release until new run.
